// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin arbiter and sequencer for a shared AXI write channel
//
// Grants the AW/W/B path to one of three masters for one complete write
// transaction (AW handshake, last W beat, B handshake), then rotates
// priority. A watchdog releases a grant whose transaction stalls.
//
// Ports:
//   sys_clk, sys_rstn         clock (rising edge), asynchronous active-low reset
//   wr_req_0..2               latched per-master write requests
//   s_awvalid, m_awready      AW handshake (granted master / slave)
//   s_wvalid, s_wlast,
//   m_wready                  W handshake and last-beat marker
//   m_bvalid, s_bready        B handshake (slave / granted master)
//   wr_grant                  one-hot grant, 3'b000 when idle
//   wr_busy                   high while a grant is active
//   wr_done                   one-cycle pulse on the accepted B handshake
//   wr_timeout                one-cycle pulse on watchdog release

module axi_wr_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       wr_req_0,
  input  logic       wr_req_1,
  input  logic       wr_req_2,
  input  logic       s_awvalid,
  input  logic       m_awready,
  input  logic       s_wvalid,
  input  logic       s_wlast,
  input  logic       m_wready,
  input  logic       m_bvalid,
  input  logic       s_bready,
  output logic [2:0] wr_grant,
  output logic       wr_busy,
  output logic       wr_done,
  output logic       wr_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last count value before forced release; only meaningful when TIMEOUT > 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       ptr;       // index of the most recently served master
  logic [1:0]       gnt_idx;   // index of the currently granted master
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] cnt;

  logic [2:0] req;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;
  logic       expire;
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] sel_idx;
  logic       sel_valid;

  assign req    = {wr_req_2, wr_req_1, wr_req_0};
  assign aw_hs  = s_awvalid && m_awready;
  assign w_hs   = s_wvalid && m_wready && s_wlast;
  assign b_hs   = m_bvalid && s_bready;
  assign expire = (TIMEOUT > 0) && (cnt == CNT_LAST);

  // Scan order starts at the master after the last one served.
  always_comb begin
    cand0 = 2'd0;
    cand1 = 2'd1;
    cand2 = 2'd2;
    case (ptr)
      2'd0: begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
      2'd1: begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
      default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
    endcase
  end

  always_comb begin
    sel_valid = |req;
    if (req[cand0])      sel_idx = cand0;
    else if (req[cand1]) sel_idx = cand1;
    else                 sel_idx = cand2;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state      <= IDLE;
      ptr        <= 2'd2;
      gnt_idx    <= 2'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      cnt        <= '0;
      wr_grant   <= 3'b000;
      wr_busy    <= 1'b0;
      wr_done    <= 1'b0;
      wr_timeout <= 1'b0;
    end else begin
      wr_done    <= 1'b0;
      wr_timeout <= 1'b0;

      // Saturating age of the current grant.
      if (state != IDLE && cnt != '1) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (sel_valid) begin
            state    <= XFER;
            gnt_idx  <= sel_idx;
            wr_grant <= 3'b001 << sel_idx;
            wr_busy  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            cnt      <= '0;
          end
        end

        XFER: begin
          if (expire) begin
            wr_timeout <= 1'b1;
            ptr        <= gnt_idx;
            wr_grant   <= 3'b000;
            wr_busy    <= 1'b0;
            state      <= IDLE;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            // AW and last W may complete in either order or together.
            if ((aw_done || aw_hs) && (w_done || w_hs)) state <= RESP;
          end
        end

        RESP: begin
          // A response on the expiry cycle still completes normally.
          if (b_hs || expire) begin
            wr_done    <= b_hs;
            wr_timeout <= !b_hs;
            ptr        <= gnt_idx;
            wr_grant   <= 3'b000;
            wr_busy    <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          wr_grant <= 3'b000;
          wr_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - self-checking bench for axi_wr_arbiter

module tb_axi_wr_arbiter;

  localparam int TMO = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rstn = 1'b0;
  logic       wr_req_0 = 1'b0, wr_req_1 = 1'b0, wr_req_2 = 1'b0;
  logic       s_awvalid = 1'b0, m_awready = 1'b0;
  logic       s_wvalid = 1'b0, s_wlast = 1'b0, m_wready = 1'b0;
  logic       m_bvalid = 1'b0, s_bready = 1'b0;
  logic [2:0] wr_grant;
  logic       wr_busy, wr_done, wr_timeout;

  int checks = 0;
  int failures = 0;

  axi_wr_arbiter #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .wr_req_0(wr_req_0), .wr_req_1(wr_req_1), .wr_req_2(wr_req_2),
    .s_awvalid(s_awvalid), .m_awready(m_awready),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .s_bready(s_bready),
    .wr_grant(wr_grant), .wr_busy(wr_busy),
    .wr_done(wr_done), .wr_timeout(wr_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the channel, what has been seen,
  // how long the owner has held it.
  int         m_owner = -1;
  int         m_last = 2;
  int         m_age = 0;
  bit         m_aw = 0, m_w = 0, m_resp = 0;
  bit         m_done = 0, m_to = 0;
  logic [2:0] m_req;

  always @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      m_owner = -1; m_last = 2; m_age = 0;
      m_aw = 0; m_w = 0; m_resp = 0; m_done = 0; m_to = 0;
    end else begin
      m_req = {wr_req_2, wr_req_1, wr_req_0};
      m_done = 0;
      m_to = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 3; k++) begin
          if (m_owner < 0 && m_req[(m_last + k) % 3]) begin
            m_owner = (m_last + k) % 3;
            m_aw = 0; m_w = 0; m_resp = 0; m_age = 0;
          end
        end
      end else begin
        if (m_resp && m_bvalid && s_bready) begin
          m_done = 1; m_last = m_owner; m_owner = -1;
        end else if (m_age == TMO - 1) begin
          m_to = 1; m_last = m_owner; m_owner = -1;
        end else if (!m_resp) begin
          if (s_awvalid && m_awready) m_aw = 1;
          if (s_wvalid && m_wready && s_wlast) m_w = 1;
          if (m_aw && m_w) m_resp = 1;
        end
        m_age++;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rstn) begin
      chk("grant", {29'd0, wr_grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("busy", {31'd0, wr_busy}, {31'd0, m_owner >= 0});
      chk("done", {31'd0, wr_done}, {31'd0, m_done});
      chk("timeout", {31'd0, wr_timeout}, {31'd0, m_to});
      chk("onehot", {31'd0, $countones(wr_grant) <= 1}, 32'd1);
      chk("done_to_excl", {31'd0, wr_done && wr_timeout}, 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic hs(input logic aw, input logic w, input logic b);
    s_awvalid = aw; m_awready = aw;
    s_wvalid = w; s_wlast = w; m_wready = w;
    m_bvalid = b; s_bready = b;
  endtask

  task automatic do_reset();
    #2 sys_rstn = 1'b0;
    {wr_req_2, wr_req_1, wr_req_0} = 3'b000;
    hs(0, 0, 0);
    step(2);
    #2 sys_rstn = 1'b1;
    step(1);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (wr_grant == 3'b000 && n < 40) begin
      step(1);
      n++;
    end
    if (wr_grant == 3'b000) chk("grant_wait", {29'd0, wr_grant}, 32'd1);
  endtask

  logic [2:0] exp_order [4];
  int n;

  initial begin
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;

    // Reset state
    do_reset();
    chk("rst_grant", {29'd0, wr_grant}, 32'd0);
    chk("rst_busy", {31'd0, wr_busy}, 32'd0);
    chk("rst_done", {31'd0, wr_done}, 32'd0);
    chk("rst_timeout", {31'd0, wr_timeout}, 32'd0);

    // Single request: grant c1, AW c3, last W c5, B c7, done c8
    wr_req_1 = 1'b1;
    step(1);
    chk("t1_grant_c1", {29'd0, wr_grant}, 32'h2);
    wr_req_1 = 1'b0;
    step(2); hs(1, 0, 0);
    step(1); hs(0, 0, 0);
    step(1); hs(0, 1, 0);
    step(1); hs(0, 0, 0);
    step(1); hs(0, 0, 1);
    step(1);
    chk("t1_done_c8", {31'd0, wr_done}, 32'd1);
    chk("t1_grant_c8", {29'd0, wr_grant}, 32'd0);
    hs(0, 0, 0);
    step(1);
    chk("t1_done_pulse", {31'd0, wr_done}, 32'd0);

    // All three requesting from reset: rotation with one idle cycle between grants
    do_reset();
    {wr_req_2, wr_req_1, wr_req_0} = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(n);
      chk("t2_gap", n, 32'd1);
      chk("t2_order", {29'd0, wr_grant}, {29'd0, exp_order[i]});
      hs(1, 1, 0);
      step(1); hs(0, 0, 1);
      step(1); hs(0, 0, 0);
    end
    {wr_req_2, wr_req_1, wr_req_0} = 3'b000;
    step(3);

    // W before AW: W c2, AW c4 -> RESP c5 (B at c4 ignored, B at c5 accepted)
    do_reset();
    wr_req_0 = 1'b1;
    step(1);
    wr_req_0 = 1'b0;
    step(1); hs(0, 1, 0);
    step(1); hs(0, 0, 0);
    step(1); hs(1, 0, 1);
    step(1);
    chk("t3_b_ignored", {31'd0, wr_done}, 32'd0);
    chk("t3_grant_held", {29'd0, wr_grant}, 32'h1);
    hs(0, 0, 1);
    step(1);
    chk("t3_done_c6", {31'd0, wr_done}, 32'd1);
    hs(0, 0, 0);

    // AW and last W together at c2 -> RESP c3; B held c2..c3 -> done c4
    do_reset();
    wr_req_2 = 1'b1;
    step(1);
    chk("t3b_grant", {29'd0, wr_grant}, 32'h4);
    wr_req_2 = 1'b0;
    step(1); hs(1, 1, 1);
    step(1); hs(0, 0, 1);
    chk("t3b_done_c3", {31'd0, wr_done}, 32'd0);
    step(1);
    chk("t3b_done_c4", {31'd0, wr_done}, 32'd1);
    hs(0, 0, 0);

    // Watchdog: master 0 stalls, master 2 pending
    do_reset();
    wr_req_0 = 1'b1; wr_req_2 = 1'b1;
    step(1);
    chk("t4_grant", {29'd0, wr_grant}, 32'h1);
    step(15);
    chk("t4_no_to_c16", {31'd0, wr_timeout}, 32'd0);
    chk("t4_held_c16", {29'd0, wr_grant}, 32'h1);
    step(1);
    chk("t4_to_c17", {31'd0, wr_timeout}, 32'd1);
    chk("t4_released", {29'd0, wr_grant}, 32'd0);
    step(1);
    chk("t4_next_m2", {29'd0, wr_grant}, 32'h4);
    wr_req_2 = 1'b0;
    hs(1, 1, 0);
    step(1); hs(0, 0, 1);
    step(1); hs(0, 0, 0);
    step(1);
    chk("t4_back_m0", {29'd0, wr_grant}, 32'h1);
    wr_req_0 = 1'b0;
    hs(1, 1, 0);
    step(1); hs(0, 0, 1);
    step(1); hs(0, 0, 0);

    // B handshake on the expiry cycle wins
    do_reset();
    wr_req_1 = 1'b1;
    step(1);
    wr_req_1 = 1'b0;
    step(1); hs(1, 1, 0);
    step(1); hs(0, 0, 0);
    step(13); hs(0, 0, 1);
    chk("t5_done_c16", {31'd0, wr_done}, 32'd0);
    step(1);
    chk("t5_done_c17", {31'd0, wr_done}, 32'd1);
    chk("t5_no_to_c17", {31'd0, wr_timeout}, 32'd0);
    chk("t5_grant_c17", {29'd0, wr_grant}, 32'd0);
    hs(0, 0, 0);

    // Asynchronous reset during XFER, then master 0 has first priority
    do_reset();
    wr_req_1 = 1'b1;
    step(1);
    chk("t6_grant", {29'd0, wr_grant}, 32'h2);
    {wr_req_2, wr_req_1, wr_req_0} = 3'b111;
    #2 sys_rstn = 1'b0;
    #1;
    chk("t6_async_grant", {29'd0, wr_grant}, 32'd0);
    chk("t6_async_busy", {31'd0, wr_busy}, 32'd0);
    chk("t6_async_done", {31'd0, wr_done}, 32'd0);
    step(1);
    #2 sys_rstn = 1'b1;
    step(1);
    chk("t6_first_m0", {29'd0, wr_grant}, 32'h1);
    {wr_req_2, wr_req_1, wr_req_0} = 3'b000;
    hs(1, 1, 0);
    step(1); hs(0, 0, 1);
    step(1); hs(0, 0, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=running expected=finished");
    $fatal(1);
  end

endmodule
